// File: rtl/count_pkg.sv
// Shared types and widths for the count tracker: the upstream counter width,
// the error tally width and the resync FSM states.
package count_pkg;

  localparam int COUNT_W   = 3;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    ERR    = 2'd2
  } trk_state_t;

endpackage

// File: rtl/count_tracker_if.sv
// Bus between the 3-bit counter side (master) and the tracker (slave).
// UPPER_W must match the UPPER_W of the count_tracker it connects to.
interface count_tracker_if
  import count_pkg::*;
#(
  parameter int UPPER_W = 5
) ();

  logic [COUNT_W-1:0]         count;
  logic [COUNT_W+UPPER_W-1:0] ext_count;
  logic                       wrap;
  logic                       locked;
  logic                       err;
  logic [ERR_CNT_W-1:0]       err_cnt;

  modport master (
    output count,
    input  ext_count, wrap, locked, err, err_cnt
  );

  modport slave (
    input  count,
    output ext_count, wrap, locked, err, err_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/count_tracker.sv
// Checks a free-running 3-bit count for +1 steps, extends it with an upper
// field on clean wraps, and tracks sequence errors with a resync FSM.
module count_tracker
  import count_pkg::*;
#(
  parameter int UPPER_W  = 5,
  parameter int RESYNC_N = 4
) (
  input  logic           clk,
  input  logic           res,
  count_tracker_if.slave bus
);

  localparam logic [3:0] RESYNC_LIM = 4'(RESYNC_N);

  trk_state_t                 state_q, state_d;
  logic [COUNT_W-1:0]         prev_q;
  logic [UPPER_W-1:0]         upper_q, upper_d;
  logic [3:0]                 run_q, run_d;
  logic [COUNT_W+UPPER_W-1:0] ext_q;
  logic                       wrap_q, wrap_d;
  logic                       good_step;
  logic                       bad_step;
  logic [ERR_CNT_W-1:0]       err_cnt_s;

  // A repeated value is also bad: the upstream counter never holds.
  assign good_step = (bus.count == (prev_q + 3'd1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    upper_d  = upper_q;
    run_d    = run_q;
    wrap_d   = 1'b0;
    bad_step = 1'b0;
    unique case (state_q)
      UNSYNC: begin
        state_d = TRACK;
        run_d   = '0;
      end
      TRACK: begin
        if (good_step) begin
          if (&prev_q) begin
            upper_d = upper_q + UPPER_W'(1);
            wrap_d  = 1'b1;
          end
        end else begin
          bad_step = 1'b1;
          state_d  = ERR;
          run_d    = '0;
        end
      end
      ERR: begin
        // upper stays frozen here, even on the step that completes resync
        if (good_step) begin
          if ((run_q + 4'd1) == RESYNC_LIM) begin
            state_d = TRACK;
            run_d   = '0;
          end else begin
            run_d = run_q + 4'd1;
          end
        end else begin
          bad_step = 1'b1;
          run_d    = '0;
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  // NOTE: reset is synchronous, so every register, outputs included, is
  // explicitly cleared in the res branch rather than relying on power-up.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= UNSYNC;
      prev_q  <= '0;
      upper_q <= '0;
      run_q   <= '0;
      ext_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= bus.count;
      upper_q <= upper_d;
      run_q   <= run_d;
      ext_q   <= {upper_d, bus.count};
      wrap_q  <= wrap_d;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .clr_i (res),
    .inc_i (bad_step),
    .q_o   (err_cnt_s)
  );

  assign bus.ext_count = ext_q;
  assign bus.wrap      = wrap_q;
  assign bus.locked    = (state_q == TRACK);
  assign bus.err       = (state_q == ERR);
  assign bus.err_cnt   = err_cnt_s;

endmodule

// File: tb/tb_count_tracker.sv
// Directed bench for count_tracker: dut_a uses the default widths, dut_b uses
// UPPER_W=2 for the upper-field wrap scenario; both see the same stimulus.
module tb_count_tracker;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  count_tracker_if #(.UPPER_W(5)) bus_a ();
  count_tracker_if #(.UPPER_W(2)) bus_b ();

  count_tracker #(.UPPER_W(5), .RESYNC_N(4)) dut_a (
    .clk (clk),
    .res (res),
    .bus (bus_a.slave)
  );

  count_tracker #(.UPPER_W(2), .RESYNC_N(4)) dut_b (
    .clk (clk),
    .res (res),
    .bus (bus_b.slave)
  );

  // Drive one count value, let one edge pass, then sample 1 ns later.
  task automatic step(input logic [2:0] c);
    bus_a.count = c;
    bus_b.count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    res = 1'b1;
    for (int i = 0; i < n; i++) step(3'd0);
    res = 1'b0;
  endtask

  task automatic test_reset_first_wrap();
    int wraps;
    int err_seen;
    wraps = 0;
    err_seen = 0;
    do_reset(2);
    checks++;
    if ({bus_a.ext_count, bus_a.wrap, bus_a.locked, bus_a.err, bus_a.err_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got ext=%h wrap=%b locked=%b err=%b err_cnt=%0d exp all zero",
               bus_a.ext_count, bus_a.wrap, bus_a.locked, bus_a.err, bus_a.err_cnt);
    end
    for (int i = 0; i <= 8; i++) begin
      step(3'(i % 8));
      wraps += int'(bus_a.wrap);
      err_seen += int'(bus_a.err);
      if (i == 0) begin
        checks++;
        if (bus_a.locked !== 1'b1) begin
          errors++;
          $display("FAIL t1_locked_first got %b exp 1", bus_a.locked);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus_a.wrap !== 1'b1) begin
          errors++;
          $display("FAIL t1_wrap_pulse got %b exp 1", bus_a.wrap);
        end
        checks++;
        if (bus_a.ext_count !== 8'h08) begin
          errors++;
          $display("FAIL t1_ext_count got %h exp 08", bus_a.ext_count);
        end
      end
    end
    step(3'd1);
    wraps += int'(bus_a.wrap);
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL t1_wrap_once got %0d exp 1", wraps);
    end
    checks++;
    if (err_seen != 0) begin
      errors++;
      $display("FAIL t1_err_quiet got %0d cycles with err exp 0", err_seen);
    end
  endtask

  task automatic test_upper_wrap();
    int wraps;
    wraps = 0;
    do_reset(1);
    step(3'd0);
    for (int k = 1; k <= 33; k++) begin
      step(3'(k % 8));
      wraps += int'(bus_b.wrap);
      if (k == 31) begin
        checks++;
        if (bus_b.ext_count !== 5'h1F) begin
          errors++;
          $display("FAIL t2_ext_before got %h exp 1f", bus_b.ext_count);
        end
      end
      if (k == 32) begin
        checks++;
        if ({bus_b.ext_count, bus_b.wrap} !== {5'h00, 1'b1}) begin
          errors++;
          $display("FAIL t2_ext_rollover got ext=%h wrap=%b exp ext=00 wrap=1",
                   bus_b.ext_count, bus_b.wrap);
        end
      end
    end
    checks++;
    if (wraps != 4) begin
      errors++;
      $display("FAIL t2_wrap_count got %0d exp 4", wraps);
    end
  endtask

  task automatic test_skip_resync();
    do_reset(1);
    step(3'd3);
    step(3'd4);
    step(3'd6);
    checks++;
    if ({bus_a.err, bus_a.locked, bus_a.err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL t3_skip got err=%b locked=%b err_cnt=%0d exp err=1 locked=0 err_cnt=1",
               bus_a.err, bus_a.locked, bus_a.err_cnt);
    end
    step(3'd7);
    step(3'd0);
    checks++;
    if ({bus_a.ext_count, bus_a.wrap} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL t3_no_wrap_in_err got ext=%h wrap=%b exp ext=00 wrap=0",
               bus_a.ext_count, bus_a.wrap);
    end
    step(3'd1);
    checks++;
    if (bus_a.locked !== 1'b0) begin
      errors++;
      $display("FAIL t3_early_lock got %b exp 0", bus_a.locked);
    end
    step(3'd2);
    checks++;
    if ({bus_a.locked, bus_a.err, bus_a.err_cnt, bus_a.ext_count} !== {1'b1, 1'b0, 8'd1, 8'h02}) begin
      errors++;
      $display("FAIL t3_relock got locked=%b err=%b err_cnt=%0d ext=%h exp locked=1 err=0 err_cnt=1 ext=02",
               bus_a.locked, bus_a.err, bus_a.err_cnt, bus_a.ext_count);
    end
  endtask

  task automatic test_stuck();
    do_reset(1);
    step(3'd4);
    step(3'd5);
    step(3'd5);
    step(3'd5);
    checks++;
    if ({bus_a.err, bus_a.err_cnt} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL t4_stuck got err=%b err_cnt=%0d exp err=1 err_cnt=2", bus_a.err, bus_a.err_cnt);
    end
    step(3'd6);
    step(3'd7);
    step(3'd0);
    checks++;
    if ({bus_a.locked, bus_a.wrap} !== 2'b00) begin
      errors++;
      $display("FAIL t4_three_good got locked=%b wrap=%b exp 0 0", bus_a.locked, bus_a.wrap);
    end
    step(3'd1);
    checks++;
    if ({bus_a.locked, bus_a.err_cnt} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL t4_relock got locked=%b err_cnt=%0d exp locked=1 err_cnt=2",
               bus_a.locked, bus_a.err_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    step(3'd0);
    for (int i = 1; i <= 300; i++) begin
      step(3'd0);
      if (i == 254 || i == 255) begin
        checks++;
        if (bus_a.err_cnt !== 8'(i)) begin
          errors++;
          $display("FAIL t5_count_%0d got %0d exp %0d", i, bus_a.err_cnt, i);
        end
      end
    end
    checks++;
    if (bus_a.err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL t5_saturated got %0d exp 255", bus_a.err_cnt);
    end
  endtask

  task automatic test_reset_mid_err();
    do_reset(1);
    step(3'd0);
    for (int i = 0; i < 7; i++) step(3'd0);
    checks++;
    if ({bus_a.err, bus_a.err_cnt} !== {1'b1, 8'd7}) begin
      errors++;
      $display("FAIL t6_pre got err=%b err_cnt=%0d exp err=1 err_cnt=7", bus_a.err, bus_a.err_cnt);
    end
    res = 1'b1;
    step(3'd5);
    res = 1'b0;
    checks++;
    if ({bus_a.ext_count, bus_a.wrap, bus_a.locked, bus_a.err, bus_a.err_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL t6_cleared got ext=%h wrap=%b locked=%b err=%b err_cnt=%0d exp all zero",
               bus_a.ext_count, bus_a.wrap, bus_a.locked, bus_a.err, bus_a.err_cnt);
    end
    step(3'd3);
    checks++;
    if ({bus_a.locked, bus_a.ext_count} !== {1'b1, 8'h03}) begin
      errors++;
      $display("FAIL t6_relock got locked=%b ext=%h exp locked=1 ext=03", bus_a.locked, bus_a.ext_count);
    end
    step(3'd4);
    checks++;
    if ({bus_a.locked, bus_a.err, bus_a.err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL t6_clean got locked=%b err=%b err_cnt=%0d exp locked=1 err=0 err_cnt=0",
               bus_a.locked, bus_a.err, bus_a.err_cnt);
    end
  endtask

  initial begin
    bus_a.count = 3'd0;
    bus_b.count = 3'd0;
    test_reset_first_wrap();
    test_upper_wrap();
    test_skip_resync();
    test_stuck();
    test_saturation();
    test_reset_mid_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
